// File: rtl/alu_result_checker_pkg.sv
// Shared constants for the ALU result checker: MISR defaults, FSM state encodings
// and the single-step MISR function used by alu_misr32.
package alu_result_checker_pkg;

    localparam int          ALU_CHK_CNT_W = 16;
    localparam logic [31:0] ALU_CHK_SEED  = 32'h0000_0000;
    localparam logic [31:0] ALU_CHK_POLY  = 32'h04C1_1DB7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Galois-form step: shift left, fold the dropped MSB back through the polynomial, mix in data.
    function automatic logic [31:0] misrStep(input logic [31:0] sig,
                                             input logic [31:0] d,
                                             input logic [31:0] poly);
        misrStep = {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ d;
    endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// Run-control and sample bus of the ALU result checker. The direct-compare signals
// exist only when ALU_CHECK_DIRECT_EN is defined.
interface alu_result_checker_if
    import alu_result_checker_pkg::*;
#(
    parameter int CNT_W = ALU_CHK_CNT_W
);
    logic             start;
    logic [CNT_W-1:0] expected_count;
    logic [31:0]      golden_sig;
    logic             sample_valid;
    logic [31:0]      alu_out;
    logic             branch_enable;
    logic             busy;
    logic             done;
    logic             pass;
    logic [31:0]      signature;
    logic [CNT_W-1:0] sample_count;
`ifdef ALU_CHECK_DIRECT_EN
    logic [31:0]      exp_result;
    logic             exp_branch;
    logic             mismatch;
    logic [CNT_W-1:0] first_fail_idx;
`endif

    modport master (
        output start, expected_count, golden_sig, sample_valid, alu_out, branch_enable,
`ifdef ALU_CHECK_DIRECT_EN
        output exp_result, exp_branch,
        input  mismatch, first_fail_idx,
`endif
        input  busy, done, pass, signature, sample_count
    );

    modport slave (
        input  start, expected_count, golden_sig, sample_valid, alu_out, branch_enable,
`ifdef ALU_CHECK_DIRECT_EN
        input  exp_result, exp_branch,
        output mismatch, first_fail_idx,
`endif
        output busy, done, pass, signature, sample_count
    );

endinterface

// File: rtl/alu_result_checker_misr.sv
// 32-bit Galois MISR used to compress the ALU result stream into a signature.
// clr reloads SEED and takes priority over en.
module alu_misr32
    import alu_result_checker_pkg::*;
#(
    parameter logic [31:0] SEED = ALU_CHK_SEED,
    parameter logic [31:0] POLY = ALU_CHK_POLY
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] sig
);

    logic [31:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= misrStep(r_sig, d, POLY);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/alu_result_checker.sv
// ALU result checker: folds N {ALUOut, Branch_Enable} samples into a MISR and compares
// against a golden signature. Define ALU_CHECK_DIRECT_EN for per-sample direct comparison.
module alu_result_checker
    import alu_result_checker_pkg::*;
#(
    parameter int          CNT_W = ALU_CHK_CNT_W,
    parameter logic [31:0] SEED  = ALU_CHK_SEED,
    parameter logic [31:0] POLY  = ALU_CHK_POLY
)(
    input logic                 clk,
    input logic                 rst,
    alu_result_checker_if.slave bus
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_target;
    logic             r_pass;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] w_count_inc;
    logic [31:0]      w_d;
    logic [31:0]      w_sig;
    logic             w_mismatch;

    assign w_start_ok  = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept    = (r_state == ST_COLLECT) && bus.sample_valid;
    assign w_count_inc = (&r_count) ? r_count : (r_count + CNT_W'(1));
    assign w_last      = w_accept && (w_count_inc == r_target);
    assign w_d         = bus.alu_out ^ {bus.branch_enable, 31'b0};

    alu_misr32 #(
        .SEED (SEED),
        .POLY (POLY)
    ) u_misr (
        .clk (clk),
        .rst (rst),
        .clr (w_start_ok),
        .en  (w_accept),
        .d   (w_d),
        .sig (w_sig)
    );

    // A zero-length run skips COLLECT; the signature is then just SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_count  <= '0;
                        r_target <= bus.expected_count;
                        r_pass   <= 1'b0;
                        r_state  <= (bus.expected_count == '0) ? ST_COMPARE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_count <= w_count_inc;
                        if (w_last) begin
                            r_state <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    r_pass  <= (w_sig == bus.golden_sig) && !w_mismatch;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_CHECK_DIRECT_EN
    logic             r_mismatch;
    logic [CNT_W-1:0] r_first_fail_idx;
    logic             w_sample_diff;

    assign w_sample_diff = {bus.alu_out, bus.branch_enable} != {bus.exp_result, bus.exp_branch};

    // Only the first differing sample of a run is recorded; the flag stays set until the next start.
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_mismatch       <= 1'b0;
            r_first_fail_idx <= '0;
        end else if (w_accept && w_sample_diff && !r_mismatch) begin
            r_mismatch       <= 1'b1;
            r_first_fail_idx <= r_count;
        end
    end

    assign w_mismatch         = r_mismatch;
    assign bus.mismatch       = r_mismatch;
    assign bus.first_fail_idx = r_first_fail_idx;
`else
    assign w_mismatch = 1'b0;
`endif

    assign bus.busy         = (r_state == ST_COLLECT) || (r_state == ST_COMPARE);
    assign bus.done         = (r_state == ST_DONE);
    assign bus.pass         = r_pass;
    assign bus.signature    = w_sig;
    assign bus.sample_count = r_count;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed, table-driven bench for alu_result_checker; the extra direct-compare test
// is built only when ALU_CHECK_DIRECT_EN is defined.
`timescale 1ns/1ps
module tb_alu_result_checker;

    typedef struct {
        logic [15:0]      cnt;
        logic [3:0][31:0] alu;
        logic [3:0]       br;
        logic [31:0]      golden;
        logic [31:0]      expSig;
        logic             expPass;
    } vec_t;

    localparam int NVEC = 6;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    alu_result_checker_if #(.CNT_W(16)) bus ();

    alu_result_checker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setVec(input int i, input logic [15:0] cnt,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3,
                          input logic [3:0] br, input logic [31:0] golden,
                          input logic [31:0] expSig, input logic expPass);
        vecs[i].cnt     = cnt;
        vecs[i].alu[0]  = a0;
        vecs[i].alu[1]  = a1;
        vecs[i].alu[2]  = a2;
        vecs[i].alu[3]  = a3;
        vecs[i].br      = br;
        vecs[i].golden  = golden;
        vecs[i].expSig  = expSig;
        vecs[i].expPass = expPass;
    endtask

    task automatic driveSample(input logic [31:0] a, input logic b, input logic [31:0] ea, input logic eb);
        bus.sample_valid  = 1'b1;
        bus.alu_out       = a;
        bus.branch_enable = b;
`ifdef ALU_CHECK_DIRECT_EN
        bus.exp_result    = ea;
        bus.exp_branch    = eb;
`else
        if (ea !== a || eb !== b) begin
            bus.alu_out = a;
        end
`endif
    endtask

    task automatic startRun(input logic [15:0] cnt, input logic [31:0] golden);
        bus.start          = 1'b1;
        bus.expected_count = cnt;
        bus.golden_sig     = golden;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic applyStimulus(input int i);
        startRun(vecs[i].cnt, vecs[i].golden);
        for (int s = 0; s < int'(vecs[i].cnt); s++) begin
            driveSample(vecs[i].alu[s], vecs[i].br[s], vecs[i].alu[s], vecs[i].br[s]);
            tick();
        end
        bus.sample_valid = 1'b0;
        checkOutput($sformatf("v%0d busy in COMPARE", i), 32'(bus.busy), 32'd1);
        checkOutput($sformatf("v%0d done in COMPARE", i), 32'(bus.done), 32'd0);
        tick();
        checkOutput($sformatf("v%0d done", i), 32'(bus.done), 32'd1);
        checkOutput($sformatf("v%0d signature", i), bus.signature, vecs[i].expSig);
        checkOutput($sformatf("v%0d pass", i), 32'(bus.pass), 32'(vecs[i].expPass));
        checkOutput($sformatf("v%0d sample_count", i), 32'(bus.sample_count), 32'(vecs[i].cnt));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, " pass"}, 32'(bus.pass), 32'd0);
        checkOutput({tag, " signature"}, bus.signature, 32'h0);
        checkOutput({tag, " sample_count"}, 32'(bus.sample_count), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.expected_count = '0;
        bus.golden_sig = '0;
        bus.sample_valid = 1'b0;
        bus.alu_out = '0;
        bus.branch_enable = 1'b0;
`ifdef ALU_CHECK_DIRECT_EN
        bus.exp_result = '0;
        bus.exp_branch = 1'b0;
`endif

        // cnt, samples a0..a3, branch bits (bit s = sample s), golden, expected sig, expected pass
        setVec(0, 16'd1, 32'h1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h1, 32'h1, 1'b1);
        setVec(1, 16'd2, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 32'h04C11DB7, 32'h04C11DB7, 1'b1);
        setVec(2, 16'd1, 32'h1, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h2, 32'h1, 1'b0);
        setVec(3, 16'd2, 32'h1, 32'h2, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
        setVec(4, 16'd3, 32'h80000000, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h09823B6E, 32'h09823B6E, 1'b1);
        setVec(5, 16'd1, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0001, 32'h0, 32'h80000000, 1'b0);

        tick();
        tick();
        rst = 1'b0;
        checkIdle("reset");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
        end

        // Intermediate signature after {0, branch=1}
        startRun(16'd2, 32'h04C11DB7);
        driveSample(32'h0, 1'b1, 32'h0, 1'b1);
        tick();
        checkOutput("intermediate sig", bus.signature, 32'h80000000);
        checkOutput("intermediate count", 32'(bus.sample_count), 32'd1);
        driveSample(32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        bus.sample_valid = 1'b0;
        tick();
        checkOutput("two-sample pass", 32'(bus.pass), 32'd1);

        // Gaps, start pulsed in COLLECT, valid asserted in DONE
        startRun(16'd2, 32'h2);
        driveSample(32'h1, 1'b0, 32'h1, 1'b0);
        tick();
        bus.sample_valid = 1'b0;
        bus.alu_out = 32'hDEADBEEF;
        tick();
        bus.start = 1'b1;
        bus.expected_count = 16'd7;
        tick();
        bus.start = 1'b0;
        tick();
        checkOutput("gap count", 32'(bus.sample_count), 32'd1);
        checkOutput("gap sig", bus.signature, 32'h1);
        checkOutput("gap busy", 32'(bus.busy), 32'd1);
        driveSample(32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        bus.sample_valid = 1'b0;
        tick();
        checkOutput("gap run done", 32'(bus.done), 32'd1);
        checkOutput("gap run sig", bus.signature, 32'h2);
        checkOutput("gap run pass", 32'(bus.pass), 32'd1);
        driveSample(32'hFFFF0000, 1'b1, 32'hFFFF0000, 1'b1);
        tick();
        tick();
        bus.sample_valid = 1'b0;
        checkOutput("done hold sig", bus.signature, 32'h2);
        checkOutput("done hold count", 32'(bus.sample_count), 32'd2);
        checkOutput("done hold done", 32'(bus.done), 32'd1);
        checkOutput("done hold pass", 32'(bus.pass), 32'd1);

        // Zero-length runs
        startRun(16'd0, 32'h0);
        checkOutput("zero busy", 32'(bus.busy), 32'd1);
        checkOutput("zero done early", 32'(bus.done), 32'd0);
        tick();
        checkOutput("zero done", 32'(bus.done), 32'd1);
        checkOutput("zero pass", 32'(bus.pass), 32'd1);
        startRun(16'd0, 32'h5);
        tick();
        checkOutput("zero bad golden pass", 32'(bus.pass), 32'd0);

        // Reset mid-run aborts
        startRun(16'd4, 32'h0);
        driveSample(32'h3, 1'b0, 32'h3, 1'b0);
        tick();
        driveSample(32'h5, 1'b1, 32'h5, 1'b1);
        tick();
        bus.sample_valid = 1'b0;
        checkOutput("pre-abort count", 32'(bus.sample_count), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle("abort");

`ifdef ALU_CHECK_DIRECT_EN
        startRun(16'd4, 32'h2);
        driveSample(32'h1, 1'b0, 32'h1, 1'b0);
        tick();
        driveSample(32'h2, 1'b0, 32'h2, 1'b0);
        tick();
        checkOutput("direct no mismatch yet", 32'(bus.mismatch), 32'd0);
        driveSample(32'h3, 1'b0, 32'h99, 1'b0);
        tick();
        driveSample(32'h4, 1'b0, 32'h77, 1'b0);
        tick();
        bus.sample_valid = 1'b0;
        tick();
        checkOutput("direct sig", bus.signature, 32'h2);
        checkOutput("direct mismatch", 32'(bus.mismatch), 32'd1);
        checkOutput("direct first_fail_idx", 32'(bus.first_fail_idx), 32'd2);
        checkOutput("direct pass", 32'(bus.pass), 32'd0);
        startRun(16'd0, 32'h0);
        checkOutput("direct clear on start", 32'(bus.mismatch), 32'd0);
        tick();
        checkOutput("direct clean pass", 32'(bus.pass), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
